alu_pipelined: RTL
==================

// Module: alu_pipelined
// PURPOSE
//  Parametrised, 2-stage pipelined ALU with valid/ready handshakes on input and output.
//  Generalises the 64-bit combinational ALU in three ways:
//   - WIDTH parameter.
//   - Adds LSL and LSR operations.
//   - Adds an architectural NZVC flag register, updated only by ops with set_flags (ADDS/SUBS style).
//  Sits between the register-file read stage and the writeback stage of the CPU datapath.
// PARAMETERS
//  WIDTH    64               operand/result width in bits, >= 8, power of 2
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (derived; do not override)
// PORTS
//  clk         in   1        single clock, rising edge
//  reset_n     in   1        synchronous reset, active low
//  in_valid    in   1        A/B/cntrl/set_flags valid this cycle
//  in_ready    out  1        pipeline can accept this cycle
//  A           in   WIDTH    operand A
//  B           in   WIDTH    operand B (shift ops use B[SHAMT_W-1:0])
//  cntrl       in   3        op select (see BEHAVIOUR)
//  set_flags   in   1        on output handshake, commit this op's flags to flags_nzvc
//  out_valid   out  1        result/flags valid
//  out_ready   in   1        downstream accepts result this cycle
//  result      out  WIDTH    operation result
//  negative    out  1        result[WIDTH-1]
//  zero        out  1        result == 0
//  overflow    out  1        signed overflow (ADD/SUB only, else 0)
//  carry_out   out  1        carry out of MSB (ADD/SUB only, else 0)
//  flags_nzvc  out  4        committed flags {N,Z,V,C}
// BEHAVIOUR
//  - Op codes:
//    - 000 pass B
//    - 001 LSL: A << shamt
//    - 010 A+B
//    - 011 A-B, computed as A + ~B + 1; carry_out=1 means no borrow
//    - 100 A&B
//    - 101 A|B
//    - 110 A^B
//    - 111 LSR: logical A >> shamt, zero fill
//  - shamt = B[SHAMT_W-1:0]. Upper bits of B are ignored for shift ops.
//  - Overflow: ADD sets it when A and B have equal sign and the result sign differs.
//    SUB sets it when A and B have different sign and the result sign differs from A.
//  - Pipeline: S1 registers A, B, cntrl, set_flags. S2 registers result and the 4 flags.
//    - advance = !out_valid || out_ready.
//    - in_ready = advance && reset_n.
//    - Global stall: when advance=0, S1 and S2 hold all contents.
//  - Accept: an edge with in_valid && in_ready. The result appears with out_valid=1 after
//    the 2nd following edge when there is no stall. Latency is 2, throughput 1 op/cycle.
//  - result, negative, zero, overflow, carry_out hold stable while out_valid && !out_ready.
//  - Commit: on an edge with out_valid && out_ready && the set_flags stored with that result,
//    flags_nzvc <= {negative, zero, overflow, carry_out}. Otherwise flags_nzvc holds.
//  - Flag commit and a new output load on the same edge are legal and independent.
//  - Reset: while reset_n=0 at a rising edge, the pipeline clears.
//    - S1/S2 valids, result, negative, zero, overflow, carry_out and flags_nzvc are cleared to 0.
//    - In-flight ops are discarded with no flag commit.
//    - in_ready=0 while reset_n=0.
//    - Mid-operation reset leaves no residue; the first op after reset behaves as from power-up.
//  - Bubbles: in_valid=0 at acceptance propagates a bubble. out_valid=0 for that slot.
// TESTING
//  - Reset: hold reset_n=0 for 2 cycles with in_valid=1.
//    -> out_valid=0, result=0, flags_nzvc=0, in_ready=0. No op accepted.
//  - ADD, WIDTH=64: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, set_flags=1, out_ready=1.
//    -> after 2 edges result=64'h8000_0000_0000_0000, N=1 Z=0 V=1 C=0.
//    -> flags_nzvc=4'b1010 after the following edge.
//  - SUB, zero case: A=B=64'h110, set_flags=0.
//    -> result=0, Z=1, C=1, V=0. flags_nzvc unchanged.
//  - Back-to-back stream: 8 ops LSL, LSR, AND, OR, XOR, passB, ADD, SUB on consecutive cycles.
//    -> 8 results on 8 consecutive cycles, in order, matching a reference model.
//    -> Check LSR of 64'h8000_0000_0000_0000 by 63 = 1.
//    -> Check LSL by 0 = A.
//  - Backpressure: out_ready=0 for 3 cycles mid-stream.
//    -> in_ready=0 during the stall.
//    -> result and flags stable while out_valid=1.
//    -> No op lost or duplicated after out_ready returns to 1.
//  - Reset mid-flight: 2 ops in S1/S2 with set_flags=1, then pulse reset_n=0 for 1 cycle.
//    -> out_valid=0, flags_nzvc=0.
//    -> A new ADD 5+3 then yields 8 after 2 edges.

Source files
------------

// File: rtl/alu_pipelined.sv
// Two-stage pipelined ALU with valid/ready handshakes and a committed NZVC flag register.
// S1 captures operands, S2 captures result and per-op flags; a stall freezes both stages.
module alu_pipelined #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags_nzvc
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LSR  = 3'b111;

    logic               s1_valid;
    logic               s1_set_flags;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [2:0]         s1_cntrl;
    logic               s2_set_flags;
    logic               advance;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_res_c;
    logic               alu_v_c;
    logic               alu_c_c;

    // Output slot free or draining this cycle: whole pipeline moves
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && reset_n;

    assign shamt    = s1_b[SHAMT_W-1:0];
    assign add_full = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_full = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);

    // Operation datapath on S1 contents
    always_comb begin
        alu_res_c = s1_b;
        alu_v_c   = 1'b0;
        alu_c_c   = 1'b0;
        case (s1_cntrl)
            OP_PASS: alu_res_c = s1_b;
            OP_LSL:  alu_res_c = s1_a << shamt;
            OP_ADD: begin
                alu_res_c = add_full[WIDTH-1:0];
                alu_c_c   = add_full[WIDTH];
                alu_v_c   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_c = sub_full[WIDTH-1:0];
                alu_c_c   = sub_full[WIDTH];
                alu_v_c   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  alu_res_c = s1_a & s1_b;
            OP_OR:   alu_res_c = s1_a | s1_b;
            OP_XOR:  alu_res_c = s1_a ^ s1_b;
            OP_LSR:  alu_res_c = s1_a >> shamt;
            default: alu_res_c = s1_b;
        endcase
    end

    // Pipeline registers and architectural flag commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_set_flags <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_cntrl     <= '0;
            s2_set_flags <= 1'b0;
            out_valid    <= 1'b0;
            result       <= '0;
            negative     <= 1'b0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            carry_out    <= 1'b0;
            flags_nzvc   <= '0;
        end else begin
            if (out_valid && out_ready && s2_set_flags) begin
                flags_nzvc <= {negative, zero, overflow, carry_out};
            end
            if (advance) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_a         <= A;
                    s1_b         <= B;
                    s1_cntrl     <= cntrl;
                    s1_set_flags <= set_flags;
                end
                // Bubbles leave the S2 payload untouched
                if (s1_valid) begin
                    result       <= alu_res_c;
                    negative     <= alu_res_c[WIDTH-1];
                    zero         <= (alu_res_c == '0);
                    overflow     <= alu_v_c;
                    carry_out    <= alu_c_c;
                    s2_set_flags <= s1_set_flags;
                end
            end
        end
    end

endmodule
